// File: rtl/cond_flag_unit_if.sv
// Signal bundle between the execute-stage decoder/ALU and cond_flag_unit.
// Valid qualifies every other decoder-side input in the same cycle; there is no back-pressure.
interface cond_flag_unit_if #(
  parameter int CNT_W = 16
);
  logic             Valid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlag;
  logic [1:0]       ALUControl;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SquashCount;

  modport master (
    output Valid, Cond, ALUFlag, ALUControl, FlagW, PCS, RegW, MemW, NoWrite,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, SquashCount
  );

  modport slave (
    input  Valid, Cond, ALUFlag, ALUControl, FlagW, PCS, RegW, MemW, NoWrite,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, SquashCount
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural condition flags, condition evaluation and write-enable gating,
// plus a saturating count of condition-failed instructions.
module cond_flag_unit #(
  parameter bit CARRY_IS_BORROW = 1'b1,
  parameter int CNT_W           = 16
) (
  input logic             clk,
  input logic             reset,
  cond_flag_unit_if.slave bus
);

  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cond_result;
  logic             cond_ex;
  logic             n_f, z_f, c_f, v_f;
  logic             c_in;

  assign n_f = flags_q[3];
  assign z_f = flags_q[2];
  assign c_f = flags_q[1];
  assign v_f = flags_q[0];

  // Conditions always read the stored flags; ALUFlag is never bypassed in.
  always_comb begin
    cond_result = 1'b0;
    case (bus.Cond)
      4'b0000: cond_result = z_f;
      4'b0001: cond_result = !z_f;
      4'b0010: cond_result = c_f;
      4'b0011: cond_result = !c_f;
      4'b0100: cond_result = n_f;
      4'b0101: cond_result = !n_f;
      4'b0110: cond_result = v_f;
      4'b0111: cond_result = !v_f;
      4'b1000: cond_result = c_f && !z_f;
      4'b1001: cond_result = !c_f || z_f;
      4'b1010: cond_result = (n_f == v_f);
      4'b1011: cond_result = (n_f != v_f);
      4'b1100: cond_result = !z_f && (n_f == v_f);
      4'b1101: cond_result = z_f || (n_f != v_f);
      4'b1110: cond_result = 1'b1;
      default: cond_result = 1'b0;
    endcase
  end

  assign cond_ex      = bus.Valid && cond_result;
  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS && cond_ex;
  assign bus.RegWrite = bus.RegW && cond_ex && !bus.NoWrite;
  assign bus.MemWrite = bus.MemW && cond_ex;
  assign bus.Flags    = flags_q;
  assign bus.SquashCount = cnt_q;

  // A subtract's ALU carry is a borrow; the architectural C is not-borrow.
  assign c_in = bus.ALUFlag[1] ^ (CARRY_IS_BORROW && (bus.ALUControl == 2'b01));

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (cond_ex) begin
      if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlag[3:2];
      if (bus.FlagW[0]) flags_q[1:0] <= {c_in, bus.ALUFlag[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.Valid && !cond_ex && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_cond_flag_unit;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   chk_en;

  cond_flag_unit_if #(.CNT_W(CNT_W)) bus ();

  cond_flag_unit #(.CARRY_IS_BORROW(1'b1), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0] m_flags;
  int         m_cnt;

  // Conditions come in pairs: odd codes are the negation of the even code below them.
  function automatic bit cond_ok(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, base;
    int pair;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    pair = int'(c) / 2;
    case (pair)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return (int'(c) % 2 == 1) ? !base : base;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_flags <= 4'b0000;
      m_cnt   <= 0;
    end else if (bus.Valid) begin
      if (cond_ok(m_flags, bus.Cond)) begin
        if (bus.FlagW[1]) m_flags[3:2] <= bus.ALUFlag[3:2];
        if (bus.FlagW[0]) begin
          m_flags[0] <= bus.ALUFlag[0];
          m_flags[1] <= (bus.ALUControl == 2'b01) ? !bus.ALUFlag[1] : bus.ALUFlag[1];
        end
      end else if (m_cnt < CNT_MAX) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ce;
    if (chk_en) begin
      ce = bus.Valid && cond_ok(m_flags, bus.Cond);
      check("cycle_condex",   32'(bus.CondEx),   32'(ce));
      check("cycle_pcsrc",    32'(bus.PCSrc),    32'(bus.PCS && ce));
      check("cycle_regwrite", 32'(bus.RegWrite), 32'(bus.RegW && ce && !bus.NoWrite));
      check("cycle_memwrite", 32'(bus.MemWrite), 32'(bus.MemW && ce));
      check("cycle_flags",    32'(bus.Flags),    32'(m_flags));
      check("cycle_count",    32'(bus.SquashCount), 32'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic v, input logic [3:0] c, input logic [3:0] af,
                     input logic [1:0] ac, input logic [1:0] fw,
                     input logic p, input logic r, input logic m, input logic nw);
    bus.Valid = v; bus.Cond = c; bus.ALUFlag = af; bus.ALUControl = ac;
    bus.FlagW = fw; bus.PCS = p; bus.RegW = r; bus.MemW = m; bus.NoWrite = nw;
  endtask

  task automatic put_rand();
    put(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    put_rand();
    step();
    chk_en = 1'b1;
    put_rand();
    step();
    check("reset_flags", 32'(bus.Flags), 32'h0);
    check("reset_count", 32'(bus.SquashCount), 32'h0);
    reset = 1'b0;

    // EQ against cleared flags fails and is counted.
    put(1, 4'b0000, 4'b0000, 2'b00, 2'b00, 1, 0, 0, 0);
    #1;
    check("eq_after_reset_condex", 32'(bus.CondEx), 32'h0);
    check("eq_after_reset_pcsrc",  32'(bus.PCSrc),  32'h0);
    step();
    check("squash_after_reset", 32'(bus.SquashCount), 32'h1);

    // Compare (SUB) then branch on EQ.
    put(1, 4'b1110, 4'b0100, 2'b01, 2'b11, 0, 1, 0, 1);
    #1;
    check("cmp_regwrite", 32'(bus.RegWrite), 32'h0);
    step();
    check("cmp_flags", 32'(bus.Flags), 32'h6);
    check("cmp_model_flags", 32'(m_flags), 32'h6);
    put(1, 4'b0000, 4'b0000, 2'b00, 2'b00, 1, 0, 0, 0);
    #1;
    check("beq_pcsrc", 32'(bus.PCSrc), 32'h1);
    step();

    // Partial writes.
    put(1, 4'b1110, 4'b1111, 2'b00, 2'b11, 0, 0, 0, 0);
    step();
    check("set_all_flags", 32'(bus.Flags), 32'hF);
    put(1, 4'b1110, 4'b0000, 2'b00, 2'b10, 0, 0, 0, 0);
    step();
    check("write_nz_only", 32'(bus.Flags), 32'h3);
    put(1, 4'b1110, 4'b0010, 2'b00, 2'b01, 0, 0, 0, 0);
    step();
    check("write_cv_only", 32'(bus.Flags), 32'h2);
    check("write_cv_model", 32'(m_flags), 32'h2);

    // Failed condition blocks writes and flag update.
    put(1, 4'b1110, 4'b0000, 2'b00, 2'b11, 0, 0, 0, 0);
    step();
    put(1, 4'b0000, 4'b0100, 2'b00, 2'b11, 0, 1, 1, 0);
    #1;
    check("squash_regwrite", 32'(bus.RegWrite), 32'h0);
    check("squash_memwrite", 32'(bus.MemWrite), 32'h0);
    step();
    check("squash_flags_hold", 32'(bus.Flags), 32'h0);
    check("squash_count_inc",  32'(bus.SquashCount), 32'h2);

    // Signed conditions with N=1, V=0.
    put(1, 4'b1110, 4'b1000, 2'b00, 2'b11, 0, 0, 0, 0);
    step();
    put(1, 4'b1011, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 0); #1;
    check("lt_n1v0", 32'(bus.CondEx), 32'h1);
    bus.Cond = 4'b1010; #1;
    check("ge_n1v0", 32'(bus.CondEx), 32'h0);
    bus.Cond = 4'b1100; #1;
    check("gt_n1v0", 32'(bus.CondEx), 32'h0);
    bus.Cond = 4'b1101; #1;
    check("le_n1v0", 32'(bus.CondEx), 32'h1);
    bus.Cond = 4'b1111; #1;
    check("never_cond", 32'(bus.CondEx), 32'h0);
    bus.Valid = 1'b0; bus.Cond = 4'b1110; bus.PCS = 1'b1; bus.MemW = 1'b1; #1;
    check("invalid_gated", 32'({bus.CondEx, bus.PCSrc, bus.MemWrite}), 32'h0);
    step();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      put_rand();
      step();
    end
    reset = 1'b0;

    // Saturation.
    reset = 1'b1;
    put(1, 4'b1111, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < CNT_MAX - 1; i++) step();
    check("count_fffe", 32'(bus.SquashCount), 32'hFFFE);
    step();
    check("count_ffff", 32'(bus.SquashCount), 32'hFFFF);
    step();
    check("count_hold", 32'(bus.SquashCount), 32'hFFFF);

    // Reset beats a passing flag write in the same cycle.
    reset = 1'b1;
    put(1, 4'b1110, 4'b1111, 2'b00, 2'b11, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    check("reset_prio_flags", 32'(bus.Flags), 32'h0);
    check("reset_prio_count", 32'(bus.SquashCount), 32'h0);
    put(1, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 0); #1;
    check("eq_cleared", 32'(bus.CondEx), 32'h0);
    bus.Cond = 4'b0001; #1;
    check("ne_cleared", 32'(bus.CondEx), 32'h1);
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
